// File: rtl/instr_loader.sv
// instr_loader: program loader that packs opcode/mode/operand beats into 9-bit
// machine words, writes them to consecutive instruction-memory addresses from 0,
// and raises done (or err) once the session finishes.
module instr_loader #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic              in_mode,
    input  logic [3:0]        in_operand,
    input  logic              in_last,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [8:0]        wr_data,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              err
);

    // Opcode map shared with the control decoder; codes 13..15 are unused.
    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_MOV = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_SHL = 4'd7;
    localparam logic [3:0] OP_SHR = 4'd8;
    localparam logic [3:0] OP_CMP = 4'd9;
    localparam logic [3:0] OP_JMP = 4'd10;
    localparam logic [3:0] OP_JZ  = 4'd11;
    localparam logic [3:0] OP_HLT = 4'd12;

    // Last usable address and the count value at which counting stops.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   MAX_COUNT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] ptr, ptr_nx;
    logic [ADDR_W:0]   count_nx;
    logic              wr_en_nx;
    logic [ADDR_W-1:0] wr_addr_nx;
    logic [8:0]        wr_data_nx;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            OP_NOP, OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
            OP_SHL, OP_SHR, OP_CMP, OP_JMP, OP_JZ, OP_HLT: op_legal = 1'b1;
            default:                                       op_legal = 1'b0;
        endcase
    endfunction

    // State, pointer and the registered write port; reset abandons any partial program.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            ptr     <= '0;
            count   <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            state   <= state_nx;
            ptr     <= ptr_nx;
            count   <= count_nx;
            wr_en   <= wr_en_nx;
            wr_addr <= wr_addr_nx;
            wr_data <= wr_data_nx;
        end
    end

    // Next-state logic: accepted legal beats become a write one cycle later, with
    // ptr/count advancing alongside; an illegal opcode or a full memory ends the
    // session in ERR, a last beat ends it in DONE.
    always_comb begin
        state_nx   = state;
        ptr_nx     = ptr;
        count_nx   = count;
        wr_en_nx   = 1'b0;
        wr_addr_nx = '0;
        wr_data_nx = '0;
        in_ready   = 1'b0;
        done       = 1'b0;
        err        = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = LOAD;
                    ptr_nx   = '0;
                    count_nx = '0;
                end
            end

            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (!op_legal(in_op)) begin
                        state_nx = ERR;
                    end else begin
                        wr_en_nx   = 1'b1;
                        wr_addr_nx = ptr;
                        wr_data_nx = {in_op, in_mode, in_operand};
                        ptr_nx     = ptr + 1'b1;
                        if (count != MAX_COUNT) begin
                            count_nx = count + 1'b1;
                        end
                        if (in_last) begin
                            state_nx = DONE;
                        end else if (ptr == LAST_ADDR) begin
                            state_nx = ERR;
                        end
                    end
                end
            end

            DONE: begin
                done = 1'b1;
                if (start) begin
                    state_nx = LOAD;
                    ptr_nx   = '0;
                    count_nx = '0;
                end
            end

            ERR: begin
                err = 1'b1;
                if (start) begin
                    state_nx = LOAD;
                    ptr_nx   = '0;
                    count_nx = '0;
                end
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: directed and randomized load sessions checked against a
// program-level reference model of the loader.
module tb_instr_loader;

    localparam int ADDR_W = 3;
    localparam int DEPTH  = 6;

    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_JMP = 4'd10;
    localparam logic [3:0] OP_MAX_LEGAL = 4'd12;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [3:0]        in_op = '0;
    logic              in_mode = 1'b0;
    logic [3:0]        in_operand = '0;
    logic              in_last = 1'b0;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [8:0]        wr_data;
    logic [ADDR_W:0]   count;
    logic              done;
    logic              err;

    int checks = 0;
    int failures = 0;

    logic [8:0] prog_word[$];
    logic       prog_last[$];
    logic [8:0] exp_word[$];
    int         exp_consumed;
    logic       exp_err;

    instr_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_mode    (in_mode),
        .in_operand (in_operand),
        .in_last    (in_last),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .count      (count),
        .done       (done),
        .err        (err)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Watchdog so a stuck DUT can never hang the run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        checkOutput({tag, "_wr_en"},    32'(wr_en),    32'd0);
        checkOutput({tag, "_wr_addr"},  32'(wr_addr),  32'd0);
        checkOutput({tag, "_wr_data"},  32'(wr_data),  32'd0);
        checkOutput({tag, "_count"},    32'(count),    32'd0);
        checkOutput({tag, "_done"},     32'(done),     32'd0);
        checkOutput({tag, "_err"},      32'(err),      32'd0);
    endtask

    task automatic driveRandomLegal();
        in_op      = 4'($urandom_range(0, 12));
        in_mode    = 1'($urandom);
        in_operand = 4'($urandom);
        in_last    = 1'($urandom);
    endtask

    task automatic addBeat(input logic [3:0] op, input logic mode,
                           input logic [3:0] operand, input logic last);
        prog_word.push_back({op, mode, operand});
        prog_last.push_back(last);
    endtask

    // Random program: legal beats, optional illegal beat, last flag at last_at.
    task automatic genProgram(input int len, input int illegal_at, input int last_at);
        prog_word.delete();
        prog_last.delete();
        for (int i = 0; i < len; i++) begin
            addBeat((i == illegal_at) ? 4'($urandom_range(13, 15)) : 4'($urandom_range(0, 12)),
                    1'($urandom), 4'($urandom), (i == last_at));
        end
    endtask

    // Reference model: which words land in memory, how many beats the loader
    // consumes, and whether the session ends in err or done.
    task automatic buildExpected();
        exp_word.delete();
        exp_consumed = prog_word.size();
        exp_err = 1'b1;
        for (int i = 0; i < prog_word.size(); i++) begin
            if (prog_word[i][8:5] > OP_MAX_LEGAL) begin
                exp_consumed = i + 1;
                exp_err = 1'b1;
                break;
            end
            exp_word.push_back(prog_word[i]);
            if (prog_last[i]) begin
                exp_consumed = i + 1;
                exp_err = 1'b0;
                break;
            end
            if (i == DEPTH - 1) begin
                exp_consumed = i + 1;
                exp_err = 1'b1;
                break;
            end
        end
    endtask

    // One session: start pulse (with a beat that must be ignored), feed the
    // program with the chosen valid pattern, then offer extra beats that must be refused.
    task automatic runSession(input int gap_mode, input int start_at);
        int  k;
        int  w;
        int  cyc;
        logic v;
        buildExpected();
        start    = 1'b1;
        in_valid = 1'b1;
        driveRandomLegal();
        applyStimulus();
        start    = 1'b0;
        in_valid = 1'b0;
        checkOutput("start_in_ready", 32'(in_ready), 32'd1);
        checkOutput("start_count",    32'(count),    32'd0);
        checkOutput("start_wr_en",    32'(wr_en),    32'd0);
        checkOutput("start_done",     32'(done),     32'd0);
        checkOutput("start_err",      32'(err),      32'd0);

        k = 0;
        w = 0;
        cyc = 0;
        while (k < exp_consumed && cyc < 200) begin
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = ((cyc % 2) == 0);
                default: v = 1'($urandom);
            endcase
            in_valid = v;
            if (v) begin
                {in_op, in_mode, in_operand} = prog_word[k];
                in_last = prog_last[k];
            end else begin
                in_op      = 4'($urandom);
                in_mode    = 1'($urandom);
                in_operand = 4'($urandom);
                in_last    = 1'($urandom);
            end
            start = (cyc == start_at);
            applyStimulus();
            start = 1'b0;
            if (v && k < exp_word.size()) begin
                checkOutput("write_en",   32'(wr_en),   32'd1);
                checkOutput("write_addr", 32'(wr_addr), 32'(k));
                checkOutput("write_data", 32'(wr_data), 32'(exp_word[k]));
                w++;
            end else begin
                checkOutput("idle_wr_en",   32'(wr_en),   32'd0);
                checkOutput("idle_wr_addr", 32'(wr_addr), 32'd0);
            end
            if (v) k++;
            checkOutput("load_in_ready", 32'(in_ready), 32'(k < exp_consumed));
            checkOutput("load_count",    32'(count),    32'(w));
            checkOutput("load_done",     32'(done),     32'(k == exp_consumed && !exp_err));
            checkOutput("load_err",      32'(err),      32'(k == exp_consumed && exp_err));
            cyc++;
        end
        checkOutput("session_beats", 32'(k), 32'(exp_consumed));

        for (int t = 0; t < 3; t++) begin
            in_valid = 1'b1;
            driveRandomLegal();
            applyStimulus();
            checkOutput("after_wr_en",    32'(wr_en),    32'd0);
            checkOutput("after_in_ready", 32'(in_ready), 32'd0);
            checkOutput("after_count",    32'(count),    32'(exp_word.size()));
            checkOutput("after_done",     32'(done),     32'(!exp_err));
            checkOutput("after_err",      32'(err),      32'(exp_err));
        end
        in_valid = 1'b0;
    endtask

    // Directed sequence followed by randomized sessions.
    initial begin
        int len;
        int illegal_at;

        reset_n = 1'b0;
        applyStimulus();
        applyStimulus();
        checkAllZero("reset");
        reset_n = 1'b1;
        applyStimulus();
        checkOutput("idle_no_start_in_ready", 32'(in_ready), 32'd0);

        $display("[TB] basic three-word program");
        prog_word.delete();
        prog_last.delete();
        addBeat(OP_ADD, 1'b0, 4'd3, 1'b0);
        addBeat(OP_SUB, 1'b1, 4'd2, 1'b0);
        addBeat(OP_JMP, 1'b0, 4'd5, 1'b1);
        runSession(0, -1);

        $display("[TB] restart from DONE with start pulsed mid-load");
        genProgram(4, -1, 3);
        runSession(0, 1);

        $display("[TB] back-pressure, valid every other cycle");
        genProgram(5, -1, 4);
        runSession(1, -1);

        $display("[TB] illegal opcode as second beat");
        genProgram(3, 1, 2);
        runSession(0, -1);

        $display("[TB] overflow without last");
        genProgram(DEPTH + 2, -1, -1);
        runSession(2, -1);

        $display("[TB] exactly DEPTH words with last on the final one");
        genProgram(DEPTH, -1, DEPTH - 1);
        runSession(2, -1);

        $display("[TB] randomized sessions");
        for (int s = 0; s < 8; s++) begin
            len = $urandom_range(1, DEPTH + 2);
            illegal_at = ($urandom_range(0, 2) == 0) ? $urandom_range(0, len - 1) : -1;
            genProgram(len, illegal_at, (len <= DEPTH) ? len - 1 : -1);
            runSession(2, $urandom_range(0, 3));
        end

        $display("[TB] reset mid-session after two writes");
        start = 1'b1;
        applyStimulus();
        start = 1'b0;
        in_valid = 1'b1;
        in_op = OP_ADD; in_mode = 1'b0; in_operand = 4'd1; in_last = 1'b0;
        applyStimulus();
        in_op = OP_SUB; in_mode = 1'b1; in_operand = 4'd2; in_last = 1'b0;
        applyStimulus();
        checkOutput("pre_reset_addr",  32'(wr_addr), 32'd1);
        checkOutput("pre_reset_count", 32'(count),   32'd2);
        reset_n = 1'b0;
        in_op = OP_JMP; in_mode = 1'b0; in_operand = 4'd7; in_last = 1'b0;
        applyStimulus();
        in_valid = 1'b0;
        checkAllZero("mid_reset");
        reset_n = 1'b1;
        applyStimulus();
        checkAllZero("post_reset_idle");
        genProgram(3, -1, 2);
        runSession(0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
